shared_reg_arbiter: RTL

- Round-robin write arbiter in front of one shared WIDTH-bit D-flip-flop register.
- Lets NREQ requesters take turns loading the register through a registered req/gnt handshake.
- Records which requester wrote last.
- Sits between the control FSMs that produce update values and the flip-flop storage they share.

---
 rtl/shared_reg_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register; records the last writer.
// Optional macro ARB_LOCK_EN adds a per-requester lock input allowing up to MAX_HOLD back-to-back grants.
module shared_reg_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output logic [OW-1:0]         q_owner
);

    localparam int NSLOT = 1 << OW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    if (NREQ < 1 || NREQ > 16 || MAX_HOLD < 1) begin : g_param_check
        $error("shared_reg_arbiter: parameter out of range");
    end

    // First requesting index at or after start, wrapping; MSB flags that one was found.
    function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] start);
        logic          found;
        logic [OW-1:0] idx;
        int            k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            k     = (int'(start) + i) % NREQ;
            idx   = (!found && r[k]) ? OW'(k) : idx;
            found = found | r[k];
        end
        return {found, idx};
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] i);
        logic [NREQ-1:0] v;
        for (int j = 0; j < NREQ; j++) begin
            v[j] = (OW'(j) == i);
        end
        return v;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [OW-1:0]     owner_r, owner_nxt_s;
    logic [OW-1:0]     ptr_r, next_ptr_s;
    logic [NREQ-1:0]   gnt_r, gnt_nxt_s;
    logic [NREQ-1:0]   own_oh_s;
    logic              busy_r;
    logic [WIDTH-1:0]  q_r;
    logic [OW-1:0]     q_owner_r;
    logic [OW:0]       idle_pick_s, grant_pick_s;
    logic [WIDTH-1:0]  wdata_arr_s [NSLOT];

`ifdef ARB_LOCK_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt_r, hold_nxt_s;
    logic          keep_s;
`endif

    // Pad the data table to a power of two so owner_r always indexes a defined slot.
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i < NREQ) begin : g_used
            assign wdata_arr_s[i] = wdata[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign wdata_arr_s[i] = '0;
        end
    end

    assign own_oh_s     = onehot(owner_r);
    assign next_ptr_s   = (owner_r == OW'(NREQ - 1)) ? '0 : owner_r + OW'(1);
    assign idle_pick_s  = rr_pick(req, ptr_r);
    assign grant_pick_s = rr_pick(req & ~own_oh_s, next_ptr_s);

`ifdef ARB_LOCK_EN
    assign keep_s = (|(lock & own_oh_s)) && (|(req & own_oh_s)) && (hold_cnt_r < HW'(MAX_HOLD - 1));
`endif

    // Next-state, next-owner and next-grant selection.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
`ifdef ARB_LOCK_EN
        hold_nxt_s  = hold_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (idle_pick_s[OW]) begin
                    state_nxt_s = ST_GRANT;
                    owner_nxt_s = idle_pick_s[OW-1:0];
`ifdef ARB_LOCK_EN
                    hold_nxt_s  = '0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
`ifdef ARB_LOCK_EN
                if (keep_s) begin
                    state_nxt_s = ST_GRANT;
                    hold_nxt_s  = hold_cnt_r + HW'(1);
                end else
`endif
                if (grant_pick_s[OW]) begin
                    state_nxt_s = ST_GRANT;
                    owner_nxt_s = grant_pick_s[OW-1:0];
`ifdef ARB_LOCK_EN
                    hold_nxt_s  = '0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (state_nxt_s == ST_GRANT) begin
            gnt_nxt_s = onehot(owner_nxt_s);
        end else begin
            gnt_nxt_s = '0;
        end
    end

    // State, grant and shared-register update; the write uses the owner granted in the ending cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= '0;
            ptr_r      <= '0;
            gnt_r      <= '0;
            busy_r     <= 1'b0;
            q_r        <= '0;
            q_owner_r  <= '0;
`ifdef ARB_LOCK_EN
            hold_cnt_r <= '0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            gnt_r      <= gnt_nxt_s;
            busy_r     <= |gnt_nxt_s;
`ifdef ARB_LOCK_EN
            hold_cnt_r <= hold_nxt_s;
`endif
            if (state_r == ST_GRANT) begin
                q_r       <= wdata_arr_s[owner_r];
                q_owner_r <= owner_r;
                ptr_r     <= next_ptr_s;
            end
        end
    end

    assign gnt     = gnt_r;
    assign busy    = busy_r;
    assign q       = q_r;
    assign q_owner = q_owner_r;

endmodule
